ctrl_mc: RTL and testbench

Multi-cycle control unit for the RV32I MPU core, and the successor to the single-phase ctrl block.
- Replaces the fixed two-cycle load_phase toggle with an FSM that tolerates variable-latency data memory (req/ready handshake) and flags a memory timeout.
- Inserts a configurable number of NOP bubbles after every control-flow redirect.
- Sits between instruction decode fields and the datapath muxes, ALU, comparator, reg_file and data memory.

---
 rtl/ctrl_pkg.sv | 80 ++++++++
 rtl/ctrl_mc_if.sv | 21 ++
 rtl/ctrl_dec.sv | 62 ++++++
 rtl/ctrl_mc.sv | 173 +++++++++++++++++
 tb/tb_ctrl_mc.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, func fields,
// datapath select enums and the controller state enum.
package ctrl_pkg;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'b000,
        CMP_BNE  = 3'b001,
        CMP_BLT  = 3'b010,
        CMP_BGE  = 3'b011,
        CMP_BLTU = 3'b100,
        CMP_BGEU = 3'b101
    } cmp_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_ALU   = 2'b01,
        PC_HOLD  = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_PC4 = 2'b01,
        RD_IMM = 2'b10,
        RD_MEM = 2'b11
    } rd_sel_e;

    typedef enum logic [1:0] {
        INST_FETCH = 2'b00,
        INST_NOP   = 2'b01
    } inst_sel_e;

    typedef enum logic [2:0] {
        S_RUN,
        S_MEM_WAIT,
        S_WB,
        S_FLUSH,
        S_ERROR
    } state_e;

endpackage

// File: rtl/ctrl_mc_if.sv
// Data-memory request/ready handshake between the controller and memory.
// master: drives mem_req/mem_we, samples mem_ready. slave: the reverse.
interface ctrl_mc_if;

    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );

endinterface

// File: rtl/ctrl_dec.sv
// Combinational field decoder: opcode/func3/func7 -> alu_op, cmp_op, rd_sel
// and an illegal-opcode flag. Holds no state.
module ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_op_e    alu_op,
    output cmp_op_e    cmp_op,
    output rd_sel_e    rd_sel,
    output logic       illegal
);

    logic alt;
    logic is_op;

    assign alt   = (func7 == F7_ALT);
    assign is_op = (opcode == OPC_OP);

    always_comb begin
        alu_op  = ALU_ADD;
        rd_sel  = RD_ALU;
        illegal = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                unique case (func3)
                    // Immediate forms never subtract; func7 there is imm.
                    F3_ADD:  alu_op = (is_op && alt) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OPC_LUI:            rd_sel = RD_IMM;
            OPC_JAL, OPC_JALR:  rd_sel = RD_PC4;
            OPC_LOAD:           rd_sel = RD_MEM;
            OPC_STORE,
            OPC_BRANCH:         rd_sel = RD_ALU;
            default:            illegal = 1'b1;
        endcase
    end

    always_comb begin
        cmp_op = CMP_BEQ;
        unique case (func3)
            F3_BEQ:  cmp_op = CMP_BEQ;
            F3_BNE:  cmp_op = CMP_BNE;
            F3_BLT:  cmp_op = CMP_BLT;
            F3_BGE:  cmp_op = CMP_BGE;
            F3_BLTU: cmp_op = CMP_BLTU;
            F3_BGEU: cmp_op = CMP_BGEU;
            default: cmp_op = CMP_BEQ;
        endcase
    end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control unit: RUN/MEM_WAIT/WB/FLUSH/ERROR FSM with
// memory wait timeout and post-redirect NOP bubbles.
// Ports: clk, rst (sync, active-high); opcode/func3/func7/b decode inputs;
// mem (ctrl_mc_if.master: mem_req, mem_we, mem_ready); pc_sel, inst_sel,
// reg_wr, rd_sel, alu_op, cmp_op datapath controls; busy, mem_err, illegal.
module ctrl_mc
    import ctrl_pkg::*;
#(
    parameter int unsigned BRANCH_NOPS = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            b,
    ctrl_mc_if.master       mem,
    output logic [1:0]      pc_sel,
    output logic [1:0]      inst_sel,
    output logic            reg_wr,
    output logic [1:0]      rd_sel,
    output logic [3:0]      alu_op,
    output logic [2:0]      cmp_op,
    output logic            busy,
    output logic            mem_err,
    output logic            illegal
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [2:0] NOPS    = 3'(BRANCH_NOPS);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       mem_err_q, mem_err_d;

    alu_op_e dec_alu;
    cmp_op_e dec_cmp;
    rd_sel_e dec_rd;
    logic    dec_ill;

    logic is_store;
    logic is_mem;
    logic is_branch;
    logic is_jump;

    ctrl_dec u_dec (
        .opcode  (opcode),
        .func3   (func3),
        .func7   (func7),
        .alu_op  (dec_alu),
        .cmp_op  (dec_cmp),
        .rd_sel  (dec_rd),
        .illegal (dec_ill)
    );

    assign is_store  = (opcode == OPC_STORE);
    assign is_mem    = is_store || (opcode == OPC_LOAD);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_sel      = PC_PLUS4;
        inst_sel    = INST_FETCH;
        reg_wr      = 1'b0;
        rd_sel      = dec_rd;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        alu_op      = dec_alu;
        cmp_op      = dec_cmp;
        busy        = (state_q != S_RUN);
        illegal     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (is_mem) begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = is_store;
                    if (!mem.mem_ready) begin
                        pc_sel     = PC_HOLD;
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else if (!is_store) begin
                        pc_sel  = PC_HOLD;
                        state_d = S_WB;
                    end
                end else if (is_jump || (is_branch && b)) begin
                    pc_sel = PC_ALU;
                    reg_wr = is_jump;
                    if (NOPS != 3'd0) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = NOPS;
                    end
                end else if (dec_ill) begin
                    illegal = 1'b1;
                end else begin
                    reg_wr = !is_branch;
                end
            end
            S_MEM_WAIT: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = is_store;
                pc_sel      = PC_HOLD;
                // A ready in the timeout cycle still completes the access.
                if (mem.mem_ready) begin
                    if (is_store) begin
                        pc_sel  = PC_PLUS4;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                rd_sel  = RD_MEM;
                state_d = S_RUN;
            end
            S_FLUSH: begin
                inst_sel    = INST_NOP;
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q == 3'd1) begin
                    state_d = S_RUN;
                end
            end
            S_ERROR: begin
                pc_sel   = PC_HOLD;
                inst_sel = INST_NOP;
            end
            default: state_d = S_RUN;
        endcase

        mem_err_d = mem_err_q || (state_d == S_ERROR);
        mem_err   = mem_err_q;

        if (rst) begin
            pc_sel      = PC_HOLD;
            inst_sel    = INST_NOP;
            reg_wr      = 1'b0;
            rd_sel      = RD_ALU;
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            alu_op      = ALU_ADD;
            cmp_op      = CMP_BEQ;
            busy        = 1'b0;
            mem_err     = 1'b0;
            illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 8'd0;
            flush_cnt_q <= 3'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: each scenario pushes per-cycle expected
// outputs when it drives stimulus and pops/compares them before the edge.
module tb_ctrl_mc;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] pc;
        logic [1:0] inst;
        logic       wr;
        logic [1:0] rd;
        logic       req;
        logic       we;
        logic [3:0] alu;
        logic [2:0] cmp;
        logic       busy;
        logic       err;
        logic       ill;
    } obs_t;

    typedef struct packed {
        obs_t v;
        obs_t m;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [1:0] pc_sel;
    logic [1:0] inst_sel;
    logic       reg_wr;
    logic [1:0] rd_sel;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic       busy;
    logic       mem_err;
    logic       illegal;

    obs_t obs;
    sb_t  sb[$];
    int   checks;
    int   errors;

    ctrl_mc_if mif ();

    ctrl_mc #(
        .BRANCH_NOPS (2),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .func3    (func3),
        .func7    (func7),
        .b        (b),
        .mem      (mif),
        .pc_sel   (pc_sel),
        .inst_sel (inst_sel),
        .reg_wr   (reg_wr),
        .rd_sel   (rd_sel),
        .alu_op   (alu_op),
        .cmp_op   (cmp_op),
        .busy     (busy),
        .mem_err  (mem_err),
        .illegal  (illegal)
    );

    assign obs = {pc_sel, inst_sel, reg_wr, rd_sel,
                  mif.mem_req, mif.mem_we, alu_op, cmp_op,
                  busy, mem_err, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rd_sel is only meaningful with reg_wr, cmp_op only where a
    // branch is being resolved, alu_op not for an illegal opcode.
    function automatic void push(
        logic [1:0] pc, logic [1:0] inst, logic wr, logic [1:0] rd,
        logic req, logic we, logic [3:0] alu, logic [2:0] cmp,
        logic cmp_care, logic bsy, logic err, logic ill);
        sb_t e;
        e.v.pc   = pc;
        e.v.inst = inst;
        e.v.wr   = wr;
        e.v.rd   = rd;
        e.v.req  = req;
        e.v.we   = we;
        e.v.alu  = alu;
        e.v.cmp  = cmp;
        e.v.busy = bsy;
        e.v.err  = err;
        e.v.ill  = ill;
        e.m      = '1;
        if (!wr) e.m.rd = '0;
        if (!cmp_care) e.m.cmp = '0;
        if (ill) e.m.alu = '0;
        sb.push_back(e);
    endfunction

    function automatic void push_rst();
        push(PC_HOLD, INST_NOP, 0, RD_ALU, 0, 0,
             ALU_ADD, CMP_BEQ, 1, 0, 0, 0);
    endfunction

    task automatic drive(logic r, logic [4:0] op, logic [2:0] f3,
                         logic [6:0] f7, logic bb, logic rdy);
        rst           = r;
        opcode        = op;
        func3         = f3;
        func7         = f7;
        b             = bb;
        mif.mem_ready = rdy;
    endtask

    task automatic test_reset();
        sb_t e;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(c < 2, OPC_OP, F3_ADD, F7_ALT, 0, 0);
            if (c < 2) push_rst();
            else push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                      ALU_SUB, CMP_BEQ, 1, 0, 0, 0);
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL reset c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_alu_decode();
        sb_t e;
        logic [4:0] opc[12] = '{OPC_OP, OPC_OP, OPC_OP, OPC_OP_IMM,
                                OPC_OP_IMM, OPC_OP, OPC_OP, OPC_OP_IMM,
                                OPC_OP, OPC_OP, OPC_OP_IMM, OPC_LUI};
        logic [2:0] f3[12]  = '{3'b000, 3'b101, 3'b101, 3'b101,
                                3'b000, 3'b001, 3'b010, 3'b011,
                                3'b100, 3'b110, 3'b111, 3'b000};
        logic [6:0] f7[12]  = '{7'h00, 7'h20, 7'h00, 7'h20,
                                7'h20, 7'h00, 7'h00, 7'h00,
                                7'h00, 7'h00, 7'h00, 7'h00};
        logic [3:0] alu[12] = '{4'b0000, 4'b0111, 4'b0110, 4'b0111,
                                4'b0000, 4'b0101, 4'b1000, 4'b1001,
                                4'b0010, 4'b0011, 4'b0100, 4'b0000};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(0, opc[c], f3[c], f7[c], 0, 1);
            push(PC_PLUS4, INST_FETCH, 1,
                 (c == 11) ? RD_IMM : RD_ALU, 0, 0,
                 alu[c], CMP_BEQ, 0, 0, 0, 0);
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL alu_decode c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_load_wait();
        sb_t e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, c == 3);
                push(PC_HOLD, INST_FETCH, 0, RD_ALU, 1, 0,
                     ALU_ADD, 0, 0, c != 0, 0, 0);
            end else if (c == 4) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, 1);
                push(PC_PLUS4, INST_FETCH, 1, RD_MEM, 0, 0,
                     ALU_ADD, 0, 0, 1, 0, 0);
            end else begin
                drive(0, OPC_OP_IMM, F3_ADD, 0, 0, 0);
                push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                     ALU_ADD, 0, 0, 0, 0, 0);
            end
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL load_wait c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_store();
        sb_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            unique case (c)
                0: begin
                    drive(0, OPC_STORE, F3_ADD, 0, 0, 1);
                    push(PC_PLUS4, INST_FETCH, 0, 0, 1, 1,
                         ALU_ADD, 0, 0, 0, 0, 0);
                end
                1: begin
                    drive(0, OPC_STORE, F3_ADD, 0, 0, 0);
                    push(PC_HOLD, INST_FETCH, 0, 0, 1, 1,
                         ALU_ADD, 0, 0, 0, 0, 0);
                end
                2: begin
                    drive(0, OPC_STORE, F3_ADD, 0, 0, 1);
                    push(PC_PLUS4, INST_FETCH, 0, 0, 1, 1,
                         ALU_ADD, 0, 0, 1, 0, 0);
                end
                default: begin
                    drive(0, OPC_OP, F3_XOR, 0, 0, 0);
                    push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                         ALU_XOR, 0, 0, 0, 0, 0);
                end
            endcase
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL store c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_branch();
        sb_t e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            unique case (c)
                0: begin
                    drive(0, OPC_BRANCH, F3_BNE, 0, 1, 0);
                    push(PC_ALU, INST_FETCH, 0, 0, 0, 0,
                         ALU_ADD, CMP_BNE, 1, 0, 0, 0);
                end
                1, 2: begin
                    drive(0, OPC_BRANCH, F3_BNE, 0, 1, 1);
                    push(PC_PLUS4, INST_NOP, 0, 0, 0, 0,
                         ALU_ADD, 0, 0, 1, 0, 0);
                end
                3: begin
                    drive(0, OPC_BRANCH, F3_BGE, 0, 0, 0);
                    push(PC_PLUS4, INST_FETCH, 0, 0, 0, 0,
                         ALU_ADD, CMP_BGE, 1, 0, 0, 0);
                end
                4: begin
                    drive(0, OPC_JAL, F3_ADD, 0, 0, 0);
                    push(PC_ALU, INST_FETCH, 1, RD_PC4, 0, 0,
                         ALU_ADD, 0, 0, 0, 0, 0);
                end
                5, 6: begin
                    drive(0, OPC_JAL, F3_ADD, 0, 0, 0);
                    push(PC_PLUS4, INST_NOP, 0, 0, 0, 0,
                         ALU_ADD, 0, 0, 1, 0, 0);
                end
                default: begin
                    drive(0, OPC_OP, F3_ADD, 0, 0, 0);
                    push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                         ALU_ADD, 0, 0, 0, 0, 0);
                end
            endcase
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL branch c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_timeout();
        sb_t e;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c <= 15) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, 0);
                push(PC_HOLD, INST_FETCH, 0, 0, 1, 0,
                     ALU_ADD, 0, 0, c != 0, 0, 0);
            end else if (c <= 17) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, c == 17);
                push(PC_HOLD, INST_NOP, 0, 0, 0, 0,
                     ALU_ADD, 0, 0, 1, 1, 0);
            end else if (c == 18) begin
                drive(1, OPC_LOAD, F3_ADD, 0, 0, 0);
                push_rst();
            end else begin
                drive(0, OPC_OP, F3_ADD, 0, 0, 0);
                push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                     ALU_ADD, 0, 0, 0, 0, 0);
            end
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL timeout c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_timeout_ready();
        sb_t e;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c <= 15) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, c == 15);
                push(PC_HOLD, INST_FETCH, 0, 0, 1, 0,
                     ALU_ADD, 0, 0, c != 0, 0, 0);
            end else if (c == 16) begin
                drive(0, OPC_LOAD, F3_ADD, 0, 0, 0);
                push(PC_PLUS4, INST_FETCH, 1, RD_MEM, 0, 0,
                     ALU_ADD, 0, 0, 1, 0, 0);
            end else begin
                drive(0, OPC_OP, F3_OR, 0, 0, 0);
                push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                     ALU_OR, 0, 0, 0, 0, 0);
            end
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL timeout_ready c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    task automatic test_rst_mid();
        sb_t e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            unique case (c)
                0, 1: begin
                    drive(0, OPC_LOAD, F3_ADD, 0, 0, 0);
                    push(PC_HOLD, INST_FETCH, 0, 0, 1, 0,
                         ALU_ADD, 0, 0, c != 0, 0, 0);
                end
                2: begin
                    drive(1, OPC_LOAD, F3_ADD, 0, 0, 0);
                    push_rst();
                end
                3: begin
                    drive(0, 5'b10101, F3_ADD, 0, 0, 1);
                    push(PC_PLUS4, INST_FETCH, 0, 0, 0, 0,
                         ALU_ADD, 0, 0, 0, 0, 1);
                end
                default: begin
                    drive(0, OPC_OP, F3_ADD, 0, 0, 0);
                    push(PC_PLUS4, INST_FETCH, 1, RD_ALU, 0, 0,
                         ALU_ADD, 0, 0, 0, 0, 0);
                end
            endcase
            #4;
            e = sb.pop_front();
            checks++;
            if (((obs ^ e.v) & e.m) !== '0) begin
                errors++;
                $display("FAIL rst_mid c%0d got %h exp %h mask %h",
                         c, obs, e.v, e.m);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(1, OPC_OP, F3_ADD, F7_ALT, 0, 0);
        test_reset();
        test_alu_decode();
        test_load_wait();
        test_store();
        test_branch();
        test_timeout();
        test_timeout_ready();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
